// File: rtl/lock_ctrl_param.sv
// Parametrised digital lock controller: stored password, entry buffer, error counter and
// inactivity timers, all held in one synchronous block with registered outputs.
module lock_ctrl_param #(
   parameter int unsigned           DIGITS       = 4,
   parameter logic [4*DIGITS-1:0]   DEFAULT_PSWD = 16'h1234,
   parameter int unsigned           MAX_ERR      = 3,
   parameter int unsigned           EDIT_TO      = 1000000000,
   parameter int unsigned           UNLOCK_TO    = 2000000000
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [3:0]                     switches,
   input  logic                           edit_switch,
   input  logic                           load,
   input  logic                           ok,
   input  logic                           admin_clr,
   input  logic                           set_pw,
   output logic [2:0]                     state_out,
   output logic [4*DIGITS-1:0]            entry,
   output logic [$clog2(DIGITS+1)-1:0]    entry_cnt,
   output logic [$clog2(MAX_ERR+1)-1:0]   err_cnt,
   output logic                           unlocked,
   output logic                           alarm
);

   localparam int unsigned PW   = 4 * DIGITS;
   localparam int unsigned CW   = $clog2(DIGITS + 1);
   localparam int unsigned EW   = $clog2(MAX_ERR + 1);
   localparam int unsigned TMAX = (EDIT_TO > UNLOCK_TO) ? EDIT_TO : UNLOCK_TO;
   localparam int unsigned TW   = ($clog2(TMAX) > 0) ? $clog2(TMAX) : 1;

   typedef enum logic [2:0] {
      StWaiting  = 3'd0,
      StEditing  = 3'd1,
      StUnlocked = 3'd2,
      StAlarming = 3'd3,
      StSetting  = 3'd4
   } state_e;

   state_e          r_state;
   logic [PW-1:0]   r_entry;
   logic [PW-1:0]   r_stored;
   logic [CW-1:0]   r_entry_cnt;
   logic [EW-1:0]   r_err_cnt;
   logic [TW-1:0]   r_timer;
   logic            r_edit_prev;
   logic            r_unlocked;
   logic            r_alarm;

   logic            w_edge;
   logic            w_full;
   logic            w_match;
   logic            w_load;
   logic            w_edit_to;
   logic            w_unlock_to;
   logic [PW-1:0]   w_shift;
   logic [EW-1:0]   w_err_inc;

   assign w_edge      = edit_switch ^ r_edit_prev;
   assign w_full      = (r_entry_cnt == CW'(DIGITS));
   assign w_match     = w_full && (r_entry == r_stored);
   // ok takes priority, so a load in the same cycle is never appended
   assign w_load      = load && !ok && (switches <= 4'd9) && !w_full;
   assign w_edit_to   = (r_timer == TW'(EDIT_TO - 1));
   assign w_unlock_to = (r_timer == TW'(UNLOCK_TO - 1));
   assign w_shift     = (r_entry << 4) | PW'(switches);
   assign w_err_inc   = r_err_cnt + EW'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= StWaiting;
         r_entry     <= '0;
         r_entry_cnt <= '0;
         r_err_cnt   <= '0;
         r_stored    <= DEFAULT_PSWD;
         r_timer     <= '0;
         r_edit_prev <= edit_switch;
         r_unlocked  <= 1'b0;
         r_alarm     <= 1'b0;
      end else begin
         r_edit_prev <= edit_switch;
         unique case (r_state)
            StWaiting: begin
               if (w_edge) begin
                  r_state     <= StEditing;
                  r_entry     <= '0;
                  r_entry_cnt <= '0;
                  r_timer     <= '0;
               end
            end
            StEditing, StSetting: begin
               if (ok) begin
                  r_timer <= '0;
                  if (r_state == StSetting) begin
                     // a short entry aborts the change and keeps the old password
                     if (w_full) r_stored <= r_entry;
                     r_state     <= StWaiting;
                     r_entry     <= '0;
                     r_entry_cnt <= '0;
                  end else if (w_match) begin
                     r_state    <= StUnlocked;
                     r_err_cnt  <= '0;
                     r_unlocked <= 1'b1;
                  end else begin
                     r_err_cnt   <= w_err_inc;
                     r_entry     <= '0;
                     r_entry_cnt <= '0;
                     if (w_err_inc == EW'(MAX_ERR)) begin
                        r_state <= StAlarming;
                        r_alarm <= 1'b1;
                     end
                  end
               end else if (w_load) begin
                  r_entry     <= w_shift;
                  r_entry_cnt <= r_entry_cnt + CW'(1);
                  r_timer     <= '0;
               end else if (w_edit_to) begin
                  r_state     <= StWaiting;
                  r_entry     <= '0;
                  r_entry_cnt <= '0;
                  r_timer     <= '0;
               end else begin
                  r_timer <= r_timer + TW'(1);
               end
            end
            StUnlocked: begin
               if (ok || w_unlock_to) begin
                  r_state    <= StWaiting;
                  r_unlocked <= 1'b0;
                  r_timer    <= '0;
               end else if (set_pw) begin
                  r_state     <= StSetting;
                  r_unlocked  <= 1'b0;
                  r_entry     <= '0;
                  r_entry_cnt <= '0;
                  r_timer     <= '0;
               end else begin
                  r_timer <= r_timer + TW'(1);
               end
            end
            StAlarming: begin
               if (admin_clr) begin
                  r_state     <= StWaiting;
                  r_alarm     <= 1'b0;
                  r_err_cnt   <= '0;
                  r_entry     <= '0;
                  r_entry_cnt <= '0;
                  r_timer     <= '0;
               end
            end
            default: begin
               r_state    <= StWaiting;
               r_unlocked <= 1'b0;
               r_alarm    <= 1'b0;
               r_timer    <= '0;
            end
         endcase
      end
   end

   assign state_out = r_state;
   assign entry     = r_entry;
   assign entry_cnt = r_entry_cnt;
   assign err_cnt   = r_err_cnt;
   assign unlocked  = r_unlocked;
   assign alarm     = r_alarm;

endmodule

// File: tb/tb_lock_ctrl_param.sv
// Bench for lock_ctrl_param: directed scenarios then random episodes, every cycle compared
// against a digit-queue model of the lock.
module tb_lock_ctrl_param;

   localparam int DIGITS    = 4;
   localparam int MAX_ERR   = 3;
   localparam int EDIT_TO   = 20;
   localparam int UNLOCK_TO = 30;
   localparam int MW = 0, ME = 1, MU = 2, MA = 3, MS = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  switches;
   logic        edit_switch;
   logic        load, ok, admin_clr, set_pw;
   logic [2:0]  state_out;
   logic [15:0] entry;
   logic [2:0]  entry_cnt;
   logic [1:0]  err_cnt;
   logic        unlocked, alarm;

   int checks = 0;
   int errors = 0;
   logic es_lvl = 1'b0;

   // model: mode, typed digits, stored code, error count, cycles since last activity
   int          m_mode;
   int          m_q[$];
   logic [15:0] m_stored;
   int          m_errs;
   int          m_idle;
   logic        m_prev_es;

   lock_ctrl_param #(
      .DIGITS(DIGITS), .DEFAULT_PSWD(16'h1234), .MAX_ERR(MAX_ERR),
      .EDIT_TO(EDIT_TO), .UNLOCK_TO(UNLOCK_TO)
   ) dut (
      .clk(clk), .rst(rst), .switches(switches), .edit_switch(edit_switch),
      .load(load), .ok(ok), .admin_clr(admin_clr), .set_pw(set_pw),
      .state_out(state_out), .entry(entry), .entry_cnt(entry_cnt), .err_cnt(err_cnt),
      .unlocked(unlocked), .alarm(alarm)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] pack();
      logic [15:0] v = '0;
      foreach (m_q[i]) v = {v[11:0], 4'(m_q[i])};
      return v;
   endfunction

   function automatic void model_step(input logic [3:0] sw, input logic es, input logic ld,
                                      input logic k, input logic ac, input logic sp,
                                      input logic rs);
      bit saw_edge, take;
      if (rs) begin
         m_mode = MW; m_q.delete(); m_errs = 0; m_stored = 16'h1234; m_idle = 0;
         m_prev_es = es;
         return;
      end
      saw_edge  = (es != m_prev_es);
      m_prev_es = es;
      take = ld && !k && (sw <= 4'd9) && (m_q.size() < DIGITS);
      case (m_mode)
         MW: if (saw_edge) begin m_mode = ME; m_q.delete(); m_idle = 0; end
         ME, MS: begin
            if (k) begin
               if (m_mode == MS) begin
                  if (m_q.size() == DIGITS) m_stored = pack();
                  m_q.delete();
                  m_mode = MW;
               end else if (m_q.size() == DIGITS && pack() == m_stored) begin
                  m_mode = MU; m_errs = 0;
               end else begin
                  m_errs++; m_q.delete();
                  if (m_errs == MAX_ERR) m_mode = MA;
               end
               m_idle = 0;
            end else if (take) begin
               m_q.push_back(int'(sw)); m_idle = 0;
            end else begin
               m_idle++;
               if (m_idle == EDIT_TO) begin m_mode = MW; m_q.delete(); m_idle = 0; end
            end
         end
         MU: begin
            if (k) begin
               m_mode = MW; m_idle = 0;
            end else begin
               m_idle++;
               if (m_idle == UNLOCK_TO) begin m_mode = MW; m_idle = 0; end
               else if (sp) begin m_mode = MS; m_q.delete(); m_idle = 0; end
            end
         end
         MA: if (ac) begin m_mode = MW; m_errs = 0; m_q.delete(); m_idle = 0; end
         default: m_mode = MW;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input logic [3:0] sw, input logic ld, input logic k, input logic ac,
                      input logic sp, input logic rs);
      switches = sw; edit_switch = es_lvl; load = ld; ok = k; admin_clr = ac; set_pw = sp;
      rst = rs;
      model_step(sw, es_lvl, ld, k, ac, sp, rs);
      @(posedge clk);
      #1;
      chk("state", 32'(state_out), 32'(m_mode));
      chk("entry", 32'(entry), 32'(pack()));
      chk("entry_cnt", 32'(entry_cnt), 32'(m_q.size()));
      chk("err_cnt", 32'(err_cnt), 32'(m_errs));
      chk("unlocked", 32'(unlocked), 32'(m_mode == MU));
      chk("alarm", 32'(alarm), 32'(m_mode == MA));
   endtask

   task automatic wake();
      es_lvl = ~es_lvl;
      cyc(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic key(input logic [3:0] d);
      cyc(d, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic press_ok();
      cyc(4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic code(input logic [15:0] c);
      for (int i = 0; i < DIGITS; i++) key(c[15-4*i -: 4]);
   endtask

   initial begin
      logic [3:0] d;
      int         n;
      bit         use_pw;

      cyc(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      cyc(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("rst_state", 32'(state_out), 32'd0);
      chk("rst_entry", 32'(entry), 32'd0);

      // correct unlock then unlock timeout
      wake(); code(16'h1234); press_ok();
      chk("unlock_state", 32'(state_out), 32'd2);
      chk("unlock_flag", 32'(unlocked), 32'd1);
      chk("unlock_err", 32'(err_cnt), 32'd0);
      idle(UNLOCK_TO - 1);
      chk("unlock_hold", 32'(state_out), 32'd2);
      idle(1);
      chk("unlock_timeout", 32'(state_out), 32'd0);

      // three wrong attempts -> alarm; only admin_clr leaves
      wake(); code(16'h1235); press_ok();
      chk("alarm_err1", 32'(err_cnt), 32'd1);
      code(16'h1235); press_ok();
      chk("alarm_err2", 32'(err_cnt), 32'd2);
      code(16'h1235); press_ok();
      chk("alarm_state", 32'(state_out), 32'd3);
      chk("alarm_flag", 32'(alarm), 32'd1);
      key(4'd1); press_ok(); cyc(4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); wake();
      chk("alarm_sticky", 32'(state_out), 32'd3);
      cyc(4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("admin_state", 32'(state_out), 32'd0);
      chk("admin_err", 32'(err_cnt), 32'd0);

      // overflow and invalid digits
      wake(); code(16'h1234); key(4'd9); key(4'hC);
      chk("ovf_entry", 32'(entry), 32'h1234);
      chk("ovf_cnt", 32'(entry_cnt), 32'd4);
      press_ok();
      chk("ovf_unlock", 32'(state_out), 32'd2);
      press_ok();
      chk("relock", 32'(state_out), 32'd0);

      // password change
      wake(); code(16'h1234); press_ok();
      cyc(4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("setting_state", 32'(state_out), 32'd4);
      code(16'h9876); press_ok();
      chk("pw_saved", 32'(state_out), 32'd0);
      wake(); code(16'h1234); press_ok();
      chk("old_pw_err", 32'(err_cnt), 32'd1);
      code(16'h9876); press_ok();
      chk("new_pw_unlock", 32'(state_out), 32'd2);
      press_ok();

      // edit timeout keeps err_cnt
      wake(); key(4'd5); press_ok(); key(4'd1);
      idle(EDIT_TO - 1);
      chk("to_hold", 32'(state_out), 32'd1);
      idle(1);
      chk("to_state", 32'(state_out), 32'd0);
      chk("to_entry", 32'(entry), 32'd0);
      chk("to_err", 32'(err_cnt), 32'd1);

      // mid-operation reset restores the default password
      wake(); code(16'h9876); press_ok(); cyc(4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      code(16'h5555); press_ok();
      wake(); key(4'd9); key(4'd8);
      chk("pre_rst_cnt", 32'(entry_cnt), 32'd2);
      cyc(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("rst_mid_state", 32'(state_out), 32'd0);
      chk("rst_mid_cnt", 32'(entry_cnt), 32'd0);
      wake(); code(16'h1234); press_ok();
      chk("rst_default_pw", 32'(state_out), 32'd2);
      press_ok();

      // collisions: ok beats load, ok beats set_pw
      wake(); key(4'd1); key(4'd2); key(4'd3);
      cyc(4'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("ok_load_state", 32'(state_out), 32'd1);
      chk("ok_load_err", 32'(err_cnt), 32'd1);
      code(16'h1234); press_ok();
      cyc(4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      chk("ok_setpw_state", 32'(state_out), 32'd0);

      // random episodes
      for (int ep = 0; ep < 60; ep++) begin
         wake();
         use_pw = ($urandom_range(0, 2) != 0);
         for (int i = 0; i < DIGITS; i++) begin
            d = use_pw ? m_stored[15-4*i -: 4] : 4'($urandom_range(0, 15));
            key(d);
         end
         press_ok();
         n = $urandom_range(0, 12);
         for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 19) == 0) es_lvl = ~es_lvl;
            cyc(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 6) == 0), 1'($urandom_range(0, 9) == 0),
                1'($urandom_range(0, 6) == 0), 1'($urandom_range(0, 49) == 0));
         end
         if ($urandom_range(0, 4) == 0) idle(UNLOCK_TO);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
